hazard_detection_unit: RTL and testbench

Pipeline-control counterpart to the EX-stage forwarding unit. Forwarding routes results forward. This block holds instructions back when a value cannot be forwarded in time. It detects load-use hazards in ID, sequences multi-cycle MUL/DIV occupancy of EX, flushes on taken branches, honours data-memory stalls, and keeps a stall-cycle counter for performance analysis.

---
 rtl/hazard_detection_unit.sv | 133 +++++++++++++
 tb/tb_hazard_detection_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_detection_unit.sv
// Pipeline hazard control: load-use stalls, multi-cycle MUL/DIV occupancy of EX,
// taken-branch flushes, data-memory freezes and a saturating stall-cycle counter.
module hazard_detection_unit #(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IF_ID_Rs1,
    input  logic [4:0]       IF_ID_Rs2,
    input  logic             IF_ID_UseRs2,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_Rd,
    input  logic             ID_EX_MulDiv,
    input  logic             Branch_Taken_i,
    input  logic             DMem_Stall_i,
    input  logic             Clr_Cnt_i,
    output logic             PCWrite_o,
    output logic             IF_ID_Write_o,
    output logic             IF_ID_Flush_o,
    output logic             ID_EX_Write_o,
    output logic             ID_EX_Bubble_o,
    output logic             EX_MEM_Bubble_o,
    output logic             MulDiv_Done_o,
    output logic [CNT_W-1:0] Stall_Cnt_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // The start cycle already stalls, so BUSY only needs LAT-2 more stall cycles before done.
    localparam logic [3:0] BUSY_LOAD = 4'(MULDIV_LAT - 2);

    state_t           state;
    state_t           state_next;
    logic [3:0]       cnt;
    logic [3:0]       cnt_next;
    logic [CNT_W-1:0] stall_cnt;
    logic             load_use_hit;

    assign load_use_hit = ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
                          ((ID_EX_Rd == IF_ID_Rs1) ||
                           (IF_ID_UseRs2 && (ID_EX_Rd == IF_ID_Rs2)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A data-memory stall freezes every sequencing decision until it drops.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (!DMem_Stall_i) begin
            case (state)
                IDLE: begin
                    if (ID_EX_MulDiv) begin
                        state_next = BUSY;
                        cnt_next   = BUSY_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt_next = cnt - 4'd1;
                    end else begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        PCWrite_o       = 1'b1;
        IF_ID_Write_o   = 1'b1;
        IF_ID_Flush_o   = 1'b0;
        ID_EX_Write_o   = 1'b1;
        ID_EX_Bubble_o  = 1'b0;
        EX_MEM_Bubble_o = 1'b0;
        MulDiv_Done_o   = 1'b0;
        if (rst_i) begin
            PCWrite_o = 1'b1;
        end else if (DMem_Stall_i) begin
            PCWrite_o     = 1'b0;
            IF_ID_Write_o = 1'b0;
            ID_EX_Write_o = 1'b0;
        end else if ((state == BUSY) && (cnt != 4'd0)) begin
            PCWrite_o       = 1'b0;
            IF_ID_Write_o   = 1'b0;
            ID_EX_Write_o   = 1'b0;
            EX_MEM_Bubble_o = 1'b1;
        end else if (state == BUSY) begin
            MulDiv_Done_o = 1'b1;
        end else if (ID_EX_MulDiv) begin
            PCWrite_o       = 1'b0;
            IF_ID_Write_o   = 1'b0;
            ID_EX_Write_o   = 1'b0;
            EX_MEM_Bubble_o = 1'b1;
        end else if (Branch_Taken_i) begin
            // The hazarding instruction in ID is being flushed, so a load-use hit is moot.
            IF_ID_Flush_o  = 1'b1;
            ID_EX_Bubble_o = 1'b1;
        end else if (load_use_hit) begin
            PCWrite_o      = 1'b0;
            IF_ID_Write_o  = 1'b0;
            ID_EX_Bubble_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (Clr_Cnt_i) begin
            stall_cnt <= '0;
        end else if (!PCWrite_o && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign Stall_Cnt_o = stall_cnt;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Scoreboard bench: the stimulus process predicts each cycle's outputs from a
// cycle-count model of the hazard rules, and a monitor compares them at negedge.
module tb_hazard_detection_unit;

    localparam int MULDIV_LAT = 4;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       rst;
        logic       dmem;
        logic       clr;
        logic       muldiv;
        logic       branch;
        logic       memread;
        logic       use_rs2;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } stim_t;

    typedef struct packed {
        logic             pc_write;
        logic             if_id_write;
        logic             if_id_flush;
        logic             id_ex_write;
        logic             id_ex_bubble;
        logic             ex_mem_bubble;
        logic             done;
        logic [CNT_W-1:0] stall_cnt;
    } resp_t;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [4:0]       IF_ID_Rs1;
    logic [4:0]       IF_ID_Rs2;
    logic             IF_ID_UseRs2;
    logic             ID_EX_MemRead;
    logic [4:0]       ID_EX_Rd;
    logic             ID_EX_MulDiv;
    logic             Branch_Taken_i;
    logic             DMem_Stall_i;
    logic             Clr_Cnt_i;
    logic             PCWrite_o;
    logic             IF_ID_Write_o;
    logic             IF_ID_Flush_o;
    logic             ID_EX_Write_o;
    logic             ID_EX_Bubble_o;
    logic             EX_MEM_Bubble_o;
    logic             MulDiv_Done_o;
    logic [CNT_W-1:0] Stall_Cnt_o;

    resp_t exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad   = 0;

    // Model: age of the MUL/DIV in EX counted in non-frozen cycles (-1 = none), stall tally.
    int md_age   = -1;
    int sc_model = 0;

    hazard_detection_unit #(
        .MULDIV_LAT(MULDIV_LAT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .IF_ID_Rs1      (IF_ID_Rs1),
        .IF_ID_Rs2      (IF_ID_Rs2),
        .IF_ID_UseRs2   (IF_ID_UseRs2),
        .ID_EX_MemRead  (ID_EX_MemRead),
        .ID_EX_Rd       (ID_EX_Rd),
        .ID_EX_MulDiv   (ID_EX_MulDiv),
        .Branch_Taken_i (Branch_Taken_i),
        .DMem_Stall_i   (DMem_Stall_i),
        .Clr_Cnt_i      (Clr_Cnt_i),
        .PCWrite_o      (PCWrite_o),
        .IF_ID_Write_o  (IF_ID_Write_o),
        .IF_ID_Flush_o  (IF_ID_Flush_o),
        .ID_EX_Write_o  (ID_EX_Write_o),
        .ID_EX_Bubble_o (ID_EX_Bubble_o),
        .EX_MEM_Bubble_o(EX_MEM_Bubble_o),
        .MulDiv_Done_o  (MulDiv_Done_o),
        .Stall_Cnt_o    (Stall_Cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic stim_t quiet();
        stim_t s;
        s = '0;
        return s;
    endfunction

    task automatic applyStimulus(input string tag, input stim_t s);
        resp_t e;
        logic  hit;
        @(posedge clk_i);
        #1;
        rst_i          = s.rst;
        DMem_Stall_i   = s.dmem;
        Clr_Cnt_i      = s.clr;
        ID_EX_MulDiv   = s.muldiv;
        Branch_Taken_i = s.branch;
        ID_EX_MemRead  = s.memread;
        IF_ID_UseRs2   = s.use_rs2;
        ID_EX_Rd       = s.rd;
        IF_ID_Rs1      = s.rs1;
        IF_ID_Rs2      = s.rs2;

        hit = s.memread && (s.rd != 5'd0) &&
              ((s.rd == s.rs1) || (s.use_rs2 && (s.rd == s.rs2)));
        e               = '0;
        e.pc_write      = 1'b1;
        e.if_id_write   = 1'b1;
        e.id_ex_write   = 1'b1;
        if (s.rst) begin
            md_age   = -1;
            sc_model = 0;
        end
        e.stall_cnt = CNT_W'(sc_model);
        if (s.rst) begin
            e.stall_cnt = '0;
        end else if (s.dmem) begin
            e.pc_write    = 1'b0;
            e.if_id_write = 1'b0;
            e.id_ex_write = 1'b0;
        end else if (md_age >= 0 || s.muldiv) begin
            if (md_age < 0) md_age = 0;
            if (md_age == MULDIV_LAT - 1) begin
                e.done = 1'b1;
                md_age = -1;
            end else begin
                e.pc_write      = 1'b0;
                e.if_id_write   = 1'b0;
                e.id_ex_write   = 1'b0;
                e.ex_mem_bubble = 1'b1;
                md_age++;
            end
        end else if (s.branch) begin
            e.if_id_flush  = 1'b1;
            e.id_ex_bubble = 1'b1;
        end else if (hit) begin
            e.pc_write     = 1'b0;
            e.if_id_write  = 1'b0;
            e.id_ex_bubble = 1'b1;
        end
        if (!s.rst) begin
            if (s.clr) sc_model = 0;
            else if (!e.pc_write && sc_model < CNT_MAX) sc_model++;
        end
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic checkOutput(input string tag, input resp_t e);
        resp_t a;
        a.pc_write      = PCWrite_o;
        a.if_id_write   = IF_ID_Write_o;
        a.if_id_flush   = IF_ID_Flush_o;
        a.id_ex_write   = ID_EX_Write_o;
        a.id_ex_bubble  = ID_EX_Bubble_o;
        a.ex_mem_bubble = EX_MEM_Bubble_o;
        a.done          = MulDiv_Done_o;
        a.stall_cnt     = Stall_Cnt_o;
        total++;
        if (a !== e) begin
            bad++;
            $display("[TB] FAIL %s @%0t: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                     tag, $time, a[CNT_W+6:CNT_W], a.stall_cnt, e[CNT_W+6:CNT_W], e.stall_cnt);
        end
    endtask

    // Monitor: the DUT presents a full output vector every cycle; check each one queued.
    initial begin
        resp_t e;
        string t;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                checkOutput(t, e);
            end
        end
    end

    initial begin
        stim_t s;
        rst_i = 1'b1; DMem_Stall_i = 1'b0; Clr_Cnt_i = 1'b0; ID_EX_MulDiv = 1'b0;
        Branch_Taken_i = 1'b0; ID_EX_MemRead = 1'b0; IF_ID_UseRs2 = 1'b0;
        ID_EX_Rd = 5'd0; IF_ID_Rs1 = 5'd0; IF_ID_Rs2 = 5'd0;

        s = quiet(); s.rst = 1'b1;
        repeat (3) applyStimulus("reset", s);
        s = quiet(); applyStimulus("post_reset", s);

        s = quiet(); s.memread = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5;
        applyStimulus("load_use_rs1", s);
        s = quiet(); applyStimulus("load_use_after", s);
        s = quiet(); s.memread = 1'b1; s.rd = 5'd0; s.rs1 = 5'd0;
        applyStimulus("load_use_rd0", s);
        s = quiet(); s.memread = 1'b1; s.rd = 5'd5; s.rs1 = 5'd7; s.rs2 = 5'd5;
        applyStimulus("load_use_rs2_unused", s);
        s.use_rs2 = 1'b1;
        applyStimulus("load_use_rs2_used", s);
        s = quiet(); s.clr = 1'b1; applyStimulus("clear", s);

        for (int i = 0; i < 6; i++) begin
            s = quiet(); s.muldiv = (i < MULDIV_LAT);
            applyStimulus("muldiv", s);
        end

        s = quiet(); s.branch = 1'b1; s.memread = 1'b1; s.rd = 5'd9; s.rs1 = 5'd9;
        applyStimulus("branch_over_load_use", s);
        s = quiet(); applyStimulus("after_branch", s);
        s = quiet(); s.muldiv = 1'b1; s.branch = 1'b1;
        applyStimulus("muldiv_over_branch", s);
        for (int i = 0; i < 4; i++) begin
            s = quiet(); s.branch = 1'b1; applyStimulus("muldiv_branch_tail", s);
        end

        s = quiet(); s.clr = 1'b1; applyStimulus("clear", s);
        for (int i = 0; i < 8; i++) begin
            s = quiet(); s.muldiv = (i < 6); s.dmem = (i == 1 || i == 2);
            applyStimulus("dmem_in_busy", s);
        end

        s = quiet(); s.clr = 1'b1; applyStimulus("clear", s);
        for (int i = 0; i < 20; i++) begin
            s = quiet(); s.dmem = 1'b1; applyStimulus("saturate", s);
        end
        s = quiet(); applyStimulus("saturated", s);
        s = quiet(); s.clr = 1'b1; s.dmem = 1'b1; applyStimulus("clear_over_inc", s);
        s = quiet(); applyStimulus("cleared", s);

        for (int i = 0; i < 7; i++) begin
            s = quiet(); s.muldiv = (i < 2); s.rst = (i == 2);
            applyStimulus("reset_mid_busy", s);
        end

        for (int i = 0; i < 600; i++) begin
            s         = quiet();
            s.rst     = ($urandom_range(0, 63) == 0);
            s.clr     = ($urandom_range(0, 31) == 0);
            s.dmem    = ($urandom_range(0, 5) == 0);
            s.muldiv  = ($urandom_range(0, 4) == 0);
            s.branch  = ($urandom_range(0, 4) == 0);
            s.memread = ($urandom_range(0, 1) == 0);
            s.use_rs2 = ($urandom_range(0, 1) == 0);
            s.rd      = 5'($urandom_range(0, 3));
            s.rs1     = 5'($urandom_range(0, 3));
            s.rs2     = 5'($urandom_range(0, 3));
            applyStimulus("random", s);
        end

        @(negedge clk_i);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: got %0d pending responses, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
